// File: rtl/alu_4b_pkg.sv
// alu_4b_pkg: opcode encoding and default datapath width shared by the ALU files.
package alu_4b_pkg;

   localparam int ALU_WIDTH_DEFAULT = 4;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_ADD  = 3'b010,
      OP_RSVD = 3'b011,
      OP_ANDN = 3'b100,
      OP_ORN  = 3'b101,
      OP_SUB  = 3'b110,
      OP_SLT  = 3'b111
   } op_e;

   // Only add and subtract report the adder's carry/overflow; every other
   // opcode (including set-less-than, which uses the adder internally) reports 0.
   function automatic logic op_reports_adder_flags(op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_4b_addsub.sv
// alu_4b_addsub: WIDTH-bit adder with optional inversion of b and a carry-in.
// Subtraction is a + ~b + 1 (invert_b=1, carry_in=1). Purely combinational.
module alu_4b_addsub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             invert_b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   full;

   // One extra bit on the sum captures the carry-out; signed overflow is when
   // both addends share a sign that the result does not.
   always_comb begin
      b_eff     = invert_b ? ~b : b;
      full      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
      sum       = full[WIDTH-1:0];
      carry_out = full[WIDTH];
      overflow  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

// File: rtl/alu_4b.sv
// alu_4b: registered WIDTH-bit ALU with one-cycle latency.
// Build option: define ALU_FLAGS_EN to add the registered zero/carry/overflow outputs.
//
// Handshake: in_valid qualifies a, b and s on a rising clk edge. There is no
// ready; every qualified edge is accepted and yields exactly one result whose
// out_valid pulse lasts one cycle. Without in_valid, y and the flags hold.
module alu_4b
   import alu_4b_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       s,
   output logic [WIDTH-1:0] y,
   output logic             out_valid
`ifdef ALU_FLAGS_EN
   ,
   output logic             zero,
   output logic             carry,
   output logic             overflow
`endif
);

   op_e              op;
   logic             add_invert_b;
   logic [WIDTH-1:0] add_sum;
   logic             add_carry;
   logic             add_ovf;
   logic [WIDTH-1:0] res;

   logic [WIDTH-1:0] y_d, y_q;
   logic             out_valid_d, out_valid_q;

   alu_4b_addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .a         (a),
      .b         (b),
      .invert_b  (add_invert_b),
      .carry_in  (add_invert_b),
      .sum       (add_sum),
      .carry_out (add_carry),
      .overflow  (add_ovf)
   );

   // Decode the opcode and select the combinational result.
   always_comb begin
      op           = op_e'(s);
      add_invert_b = (op == OP_SUB) || (op == OP_SLT);
      res          = '0;
      case (op)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD:  res = add_sum;
         OP_RSVD: res = '0;
         OP_ANDN: res = a & ~b;
         OP_ORN:  res = a | ~b;
         OP_SUB:  res = add_sum;
         // Signed a<b: sign of a-b corrected by subtraction overflow.
         OP_SLT:  res[0] = add_sum[WIDTH-1] ^ add_ovf;
         default: res = '0;
      endcase
   end

   // Result register next-state: load on a qualified edge, otherwise hold.
   always_comb begin
      y_d         = y_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         y_d         = res;
         out_valid_d = 1'b1;
      end
   end

   // Result registers; reset wins over a simultaneous capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign y         = y_q;
   assign out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
   logic zero_d, zero_q;
   logic carry_d, carry_q;
   logic overflow_d, overflow_q;

   // Flag next-state: zero follows the loaded result; carry/overflow only for add/sub.
   always_comb begin
      zero_d     = zero_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      if (in_valid) begin
         zero_d     = (res == '0);
         carry_d    = op_reports_adder_flags(op) ? add_carry : 1'b0;
         overflow_d = op_reports_adder_flags(op) ? add_ovf : 1'b0;
      end
   end

   // Flag registers; zero is forced low in reset rather than derived from y.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
      end
   end

   assign zero     = zero_q;
   assign carry    = carry_q;
   assign overflow = overflow_q;
`else
   // Carry-out has no consumer when the flag outputs are not built.
   logic unused_add_carry;
   assign unused_add_carry = add_carry;
`endif

endmodule

// File: tb/tb_alu_4b.sv
// tb_alu_4b: self-checking bench for alu_4b (default WIDTH=4).
// Flag outputs are checked only when ALU_FLAGS_EN is defined.
module tb_alu_4b;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   s;
   logic [W-1:0] y;
   logic         out_valid;
`ifdef ALU_FLAGS_EN
   logic         zero;
   logic         carry;
   logic         overflow;
`endif

   // expected entry: {y, zero, carry, overflow}
   logic [W+2:0] exp_q[$];
   logic [W+2:0] exp_e;
   logic [W+2:0] last_exp;
   int           n_vec;
   int           n_err;

   alu_4b #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .s         (s),
      .y         (y),
      .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
      ,
      .zero      (zero),
      .carry     (carry),
      .overflow  (overflow)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Directed vectors: s, a, b, expected y, carry, overflow (worked by hand).
   localparam int ND = 14;
   localparam logic [2:0]   T_S [ND] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b010, 3'b110,
                                         3'b111, 3'b111, 3'b011, 3'b110, 3'b110, 3'b010, 3'b111};
   localparam logic [W-1:0] T_A [ND] = '{4'b0010, 4'b1100, 4'b0001, 4'b0110, 4'b1010, 4'b0111, 4'b1110,
                                         4'b1101, 4'b1011, 4'b1111, 4'b0000, 4'b1000, 4'b1111, 4'b1000};
   localparam logic [W-1:0] T_B [ND] = '{4'b0011, 4'b1011, 4'b0000, 4'b1001, 4'b0101, 4'b0001, 4'b0001,
                                         4'b1011, 4'b1101, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0111};
   localparam logic [W-1:0] T_Y [ND] = '{4'b0010, 4'b1111, 4'b0001, 4'b0110, 4'b1111, 4'b1000, 4'b1101,
                                         4'b0000, 4'b0001, 4'b0000, 4'b1111, 4'b0111, 4'b0000, 4'b0001};
   localparam logic T_C [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam logic T_V [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   // Reference model working in integers, independent of the adder structure.
   function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] ma,
                                          input logic [W-1:0] mb);
      int ua, ub, sa, sb, r, smax, smin;
      logic [W-1:0] my;
      logic mc, mv;
      ua = int'(ma);
      ub = int'(mb);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      smax = (1 << (W - 1)) - 1;
      smin = -(1 << (W - 1));
      mc = 1'b0;
      mv = 1'b0;
      my = '0;
      case (op)
         3'b000: my = ma & mb;
         3'b001: my = ma | mb;
         3'b010: begin
            r  = ua + ub;
            my = r[W-1:0];
            mc = (r >= (1 << W));
            mv = ((sa + sb) > smax) || ((sa + sb) < smin);
         end
         3'b011: my = '0;
         3'b100: my = ma & ~mb;
         3'b101: my = ma | ~mb;
         3'b110: begin
            r  = ua - ub;
            my = r[W-1:0];
            mc = (ua >= ub);
            mv = ((sa - sb) > smax) || ((sa - sb) < smin);
         end
         default: my = (sa < sb) ? 1 : 0;
      endcase
      return {my, (my == '0), mc, mv};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [2:0] op, input logic [W-1:0] da, input logic [W-1:0] db,
                        input logic [W+2:0] expv);
      s        = op;
      a        = da;
      b        = db;
      in_valid = 1'b1;
      exp_q.push_back(expv);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      s        = 3'b000;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({y, out_valid} !== {{W{1'b0}}, 1'b0}) begin
         n_err++;
         $display("FAIL reset_y_valid got y=%b ov=%b exp y=0000 ov=0", y, out_valid);
      end
`ifdef ALU_FLAGS_EN
      n_vec++;
      if ({zero, carry, overflow} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_flags got %b exp 000", {zero, carry, overflow});
      end
`endif
      rst = 1'b0;
      last_exp = '0;
   endtask

   task automatic test_directed();
      for (int i = 0; i < ND; i++) begin
         drive(T_S[i], T_A[i], T_B[i], {T_Y[i], (T_Y[i] == 4'b0000), T_C[i], T_V[i]});
         @(posedge clk);
         #1;
         idle();
         n_vec++;
         if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL dir%0d_out_valid got %b exp 1", i, out_valid);
         end
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dir%0d_queue empty got 0 entries exp 1", i);
         end else begin
            exp_e = exp_q.pop_front();
            last_exp = exp_e;
            n_vec++;
            if (y !== exp_e[W+2:3]) begin
               n_err++;
               $display("FAIL dir%0d_y s=%b a=%b b=%b got %b exp %b", i, T_S[i], T_A[i], T_B[i],
                        y, exp_e[W+2:3]);
            end
`ifdef ALU_FLAGS_EN
            n_vec++;
            if ({zero, carry, overflow} !== exp_e[2:0]) begin
               n_err++;
               $display("FAIL dir%0d_flags got zcv=%b exp %b", i, {zero, carry, overflow}, exp_e[2:0]);
            end
`endif
         end
         @(posedge clk);
         #1;
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL dir%0d_pulse out_valid got %b exp 0", i, out_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]   op;
      logic [W-1:0] ra, rb;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         ra = W'($urandom_range(0, (1 << W) - 1));
         rb = W'($urandom_range(0, (1 << W) - 1));
         drive(op, ra, rb, model(op, ra, rb));
         @(posedge clk);
         #1;
         exp_e = exp_q.pop_front();
         last_exp = exp_e;
         n_vec++;
         if ({out_valid, y} !== {1'b1, exp_e[W+2:3]}) begin
            n_err++;
            $display("FAIL b2b%0d s=%b a=%b b=%b got ov=%b y=%b exp ov=1 y=%b", i, op, ra, rb,
                     out_valid, y, exp_e[W+2:3]);
         end
`ifdef ALU_FLAGS_EN
         n_vec++;
         if ({zero, carry, overflow} !== exp_e[2:0]) begin
            n_err++;
            $display("FAIL b2b%0d_flags got zcv=%b exp %b", i, {zero, carry, overflow}, exp_e[2:0]);
         end
`endif
      end
      idle();
   endtask

   task automatic test_idle_hold();
      // Last back-to-back result must persist with out_valid low.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_vec++;
         if ({out_valid, y} !== {1'b0, last_exp[W+2:3]}) begin
            n_err++;
            $display("FAIL idle%0d got ov=%b y=%b exp ov=0 y=%b", i, out_valid, y, last_exp[W+2:3]);
         end
`ifdef ALU_FLAGS_EN
         n_vec++;
         if ({zero, carry, overflow} !== last_exp[2:0]) begin
            n_err++;
            $display("FAIL idle%0d_flags got %b exp %b", i, {zero, carry, overflow}, last_exp[2:0]);
         end
`endif
      end
   endtask

   task automatic test_reset_mid_stream();
      // Load a nonzero result first so the reset visibly clears it.
      drive(3'b001, 4'b1010, 4'b0101, model(3'b001, 4'b1010, 4'b0101));
      @(posedge clk);
      #1;
      exp_e = exp_q.pop_front();
      n_vec++;
      if (y !== exp_e[W+2:3]) begin
         n_err++;
         $display("FAIL pre_rst_y got %b exp %b", y, exp_e[W+2:3]);
      end
      // Operation offered on the reset edge is discarded (never queued).
      s = 3'b010; a = 4'b0111; b = 4'b0111; in_valid = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      n_vec++;
      if ({out_valid, y} !== {1'b0, {W{1'b0}}}) begin
         n_err++;
         $display("FAIL rst_mid got ov=%b y=%b exp ov=0 y=0000", out_valid, y);
      end
`ifdef ALU_FLAGS_EN
      n_vec++;
      if ({zero, carry, overflow} !== 3'b000) begin
         n_err++;
         $display("FAIL rst_mid_flags got %b exp 000", {zero, carry, overflow});
      end
`endif
      @(posedge clk);
      #1;
      n_vec++;
      if ({out_valid, y} !== {1'b0, {W{1'b0}}}) begin
         n_err++;
         $display("FAIL post_rst_idle got ov=%b y=%b exp ov=0 y=0000", out_valid, y);
      end
      // First capture after reset: reserved opcode gives y=0 so zero must rise.
      drive(3'b011, 4'b1111, 4'b1111, {4'b0000, 1'b1, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      idle();
      exp_e = exp_q.pop_front();
      n_vec++;
      if ({out_valid, y} !== {1'b1, exp_e[W+2:3]}) begin
         n_err++;
         $display("FAIL post_rst_op got ov=%b y=%b exp ov=1 y=%b", out_valid, y, exp_e[W+2:3]);
      end
`ifdef ALU_FLAGS_EN
      n_vec++;
      if ({zero, carry, overflow} !== exp_e[2:0]) begin
         n_err++;
         $display("FAIL post_rst_flags got %b exp %b", {zero, carry, overflow}, exp_e[2:0]);
      end
`endif
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      idle();
      test_reset();
      test_directed();
      test_back_to_back();
      test_idle_hold();
      test_reset_mid_stream();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_4b.md
ALU_4B -- requirements
Module: alu_4b

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits (SHALL support 2..32).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operands and opcode SHALL be captured on a rising edge where in_valid=1.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 s  input  3  opcode select.
REQ-008 y  output  WIDTH  registered result.
REQ-009 out_valid  output  1  high for exactly one cycle after each captured operation.
REQ-010 zero  output  1  registered; high when y is all zeros (present only with ALU_FLAGS_EN).
REQ-011 carry  output  1  registered carry-out of adder path (present only with ALU_FLAGS_EN).
REQ-012 overflow  output  1  registered signed overflow of adder path (present only with ALU_FLAGS_EN).

Function
REQ-013 Opcodes SHALL be: 000 a AND b; 001 a OR b; 010 a+b; 011 reserved; 100 a AND NOT b; 101 a OR NOT b; 110 a-b; 111 set-less-than.
REQ-014 Opcode 011 SHALL produce y=0, carry=0, overflow=0.
REQ-015 Add and subtract SHALL wrap modulo 2^WIDTH; subtract SHALL be computed as a + NOT b + 1.
REQ-016 carry SHALL be the adder carry-out for 010 and 110 (110: 1 means a>=b unsigned), and 0 for all other opcodes.
REQ-017 overflow SHALL be two's-complement overflow for 010 and 110, and 0 for all other opcodes.
REQ-018 Set-less-than SHALL treat a and b as signed, output y=1 (zero-extended) when a<b else 0, using sign of a-b XOR subtraction overflow; carry=overflow=0.
REQ-019 Latency SHALL be exactly one cycle: inputs captured at edge N appear on y/flags and out_valid=1 after edge N.
REQ-020 When in_valid=0 at an edge, y and flags SHALL hold their previous values and out_valid SHALL be 0.
REQ-021 Back-to-back in_valid=1 cycles SHALL each produce one result, no stalls, no backpressure.
REQ-022 zero SHALL reflect the registered y value, including for opcode 011.

Reset
REQ-023 While rst=1 at a rising edge, y, out_valid, zero, carry, overflow SHALL become 0, regardless of in_valid.
REQ-024 zero SHALL read 0 during reset (not derived from y=0) and resume tracking y on the first captured operation.
REQ-025 An operation captured on the same edge as rst=1 SHALL be discarded.

Configuration
REQ-026 Macro ALU_FLAGS_EN defined: zero, carry, overflow ports and their registers SHALL exist per REQ-010..012.
REQ-027 Macro ALU_FLAGS_EN undefined: flag ports and registers SHALL be absent; y and out_valid behaviour SHALL be unchanged.

Structure
REQ-028 A shared package SHALL hold the opcode enumeration (OP_AND, OP_OR, OP_ADD, OP_RSVD, OP_ANDN, OP_ORN, OP_SUB, OP_SLT) and the default WIDTH constant.
REQ-029 One combinational sub-module alu_4b_addsub SHALL implement the WIDTH-bit adder with invert-b/carry-in control and return sum, carry-out, overflow.

Verification
REQ-030 s=000, a=0010, b=0011 -> y=0010, out_valid=1 next cycle, zero=0.
REQ-031 s=001 a=1100 b=1011 -> 1111; s=100 a=0001 b=0000 -> 0001; s=101 a=0110 b=1001 -> 0110.
REQ-032 s=010 a=1010 b=0101 -> y=1111 carry=0 overflow=0; s=010 a=0111 b=0001 -> y=1000 overflow=1.
REQ-033 s=110 a=1110 b=0001 -> y=1101 carry=1; s=111 a=1101 b=1011 -> y=0000; s=111 a=1011 b=1101 -> y=0001.
REQ-034 s=011 a=1111 b=1111 -> y=0000, zero=1, carry=0, overflow=0.
REQ-035 rst=1 asserted with in_valid=1 mid-stream -> next cycle all outputs 0; in_valid=0 idle cycles -> y holds, out_valid=0.
